// File: rtl/core_pkg.sv
// core_pkg: shared sequencer state encoding and reset defaults for the RV32 core.
package core_pkg;
  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT,
    TRAP
  } state_t;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] INST_BYTES   = 32'd4;
endpackage

// File: rtl/core_sequencer_pc_next.sv
// pc_next: sequential and jump-target PC, with misaligned-target detection.
module pc_next
  import core_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        is_jump,
  output logic [31:0] pc4,
  output logic [31:0] target,
  output logic [31:0] next_pc,
  output logic        misaligned
);
  assign pc4        = pc + INST_BYTES;
  assign target     = pc + imm;
  assign misaligned = is_jump && (target[1:0] != 2'b00);
  assign next_pc    = is_jump ? target : pc4;
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/writeback control for the RV32 core.
// Owns pc, the instruction register and instret; raises a sticky trap on misaligned jumps.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_encoding,
  input  logic        dec_we,
  input  logic        dec_is_jump,
  input  logic [31:0] dec_imm,
  output logic        alu_en,
  output logic        rf_we,
  output logic        wb_sel_pc4,
  output logic [31:0] pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        trap,
  output logic [31:0] instret
);
  state_t      state, state_next;
  logic [31:0] ir;
  logic [31:0] next_pc;
  logic        misaligned;

  pc_next u_pc_next (
    .pc        (pc),
    .imm       (dec_imm),
    .is_jump   (dec_is_jump),
    .pc4       (),
    .target    (),
    .next_pc   (next_pc),
    .misaligned(misaligned)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else     state <= state_next;

  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:     state_next = imem_ack ? DECODE : FETCH;
      DECODE:    state_next = EXECUTE;
      EXECUTE:   state_next = WRITEBACK;
      WRITEBACK: state_next = misaligned ? TRAP : halt_req ? HALT : FETCH;
      HALT:      state_next = halt_req ? HALT : FETCH;
      default:   state_next = TRAP;
    endcase
  end

  // Writeback strobes are registered at the end of EXECUTE so no input reaches an output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      ir         <= NOP_INST;
      instret    <= 32'd0;
      trap       <= 1'b0;
      rf_we      <= 1'b0;
      wb_sel_pc4 <= 1'b0;
    end else begin
      if (state == FETCH && imem_ack) ir <= imem_rdata;
      rf_we      <= (state == EXECUTE) && dec_we && !misaligned;
      wb_sel_pc4 <= (state == EXECUTE) && dec_is_jump && !misaligned;
      if (state == WRITEBACK && misaligned) trap <= 1'b1;
      if (state == WRITEBACK && !misaligned) begin
        pc      <= next_pc;
        instret <= instret + 32'd1;
      end
    end
  end

  assign imem_req      = (state == FETCH) && !rst;
  assign imem_addr     = pc;
  assign inst_encoding = ir;
  assign alu_en        = state == EXECUTE;
  assign halted        = state == HALT;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed checks of fetch timing, jumps, halt, trap, wrap and reset.
module tb_core_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst_encoding;
  logic        dec_we = 1'b0;
  logic        dec_is_jump = 1'b0;
  logic [31:0] dec_imm = 32'h0;
  logic        alu_en;
  logic        rf_we;
  logic        wb_sel_pc4;
  logic [31:0] pc;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        trap;
  logic [31:0] instret;
  int          errors = 0;
  int          checks = 0;

  core_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_encoding(inst_encoding),
    .dec_we       (dec_we),
    .dec_is_jump  (dec_is_jump),
    .dec_imm      (dec_imm),
    .alu_en       (alu_en),
    .rf_we        (rf_we),
    .wb_sel_pc4   (wb_sel_pc4),
    .pc           (pc),
    .halt_req     (halt_req),
    .halted       (halted),
    .trap         (trap),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait fetch from a FETCH negedge; returns at the WRITEBACK negedge.
  task automatic run_inst(input logic [31:0] inst, input logic we, input logic jump, input logic [31:0] imm);
    imem_rdata  = inst;
    dec_we      = we;
    dec_is_jump = jump;
    dec_imm     = imm;
    imem_ack    = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", inst_encoding, 32'h13);
    chk("rst_instret", instret, 0);
    chk("rst_trap", trap, 0);
    chk("rst_strobes", {alu_en, rf_we, wb_sel_pc4, halted}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 32'h0);
    // addi x1,x0,5 with zero-wait ack: cycles 1..5
    imem_rdata = 32'h0050_0093; dec_we = 1'b1; dec_imm = 32'd5; imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("c2_ir", inst_encoding, 32'h0050_0093);
    chk("c2_req", imem_req, 0);
    chk("c2_alu", alu_en, 0);
    @(negedge clk);
    chk("c3_alu", alu_en, 1);
    chk("c3_rfwe", rf_we, 0);
    @(negedge clk);
    chk("c4_alu", alu_en, 0);
    chk("c4_rfwe", rf_we, 1);
    chk("c4_wbsel", wb_sel_pc4, 0);
    chk("c4_pc", pc, 32'h0);
    @(negedge clk);
    chk("c5_pc", pc, 32'h4);
    chk("c5_instret", instret, 1);
    chk("c5_rfwe", rf_we, 0);
    chk("c5_req", imem_req, 1);
    // Delayed ack: three wait cycles, unknown opcode retires as NOP
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, 32'h4);
      @(negedge clk);
    end
    run_inst(32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    chk("unk_rfwe", rf_we, 0);
    @(negedge clk);
    chk("unk_pc", pc, 32'h8);
    chk("unk_instret", instret, 2);
    run_inst(32'h13, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    run_inst(32'h13, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("pre_jal_pc", pc, 32'h10);
    // JAL +8 at 0x10
    run_inst(32'h0080_00EF, 1'b1, 1'b1, 32'd8);
    chk("jal_rfwe", rf_we, 1);
    chk("jal_wbsel", wb_sel_pc4, 1);
    chk("jal_wb_pc", pc, 32'h10);
    @(negedge clk);
    chk("jal_pc", pc, 32'h18);
    chk("jal_instret", instret, 5);
    chk("jal_rfwe_low", rf_we, 0);
    // halt_req raised during EXECUTE and held
    imem_rdata = 32'h13; dec_we = 1'b0; dec_is_jump = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    halt_req = 1'b1;
    chk("halt_exec_alu", alu_en, 1);
    @(negedge clk);
    chk("halt_wb_halted", halted, 0);
    @(negedge clk);
    chk("halted", halted, 1);
    chk("halt_req_off", imem_req, 0);
    chk("halt_pc", pc, 32'h1C);
    chk("halt_instret", instret, 6);
    @(negedge clk);
    @(negedge clk);
    chk("halt_hold", halted, 1);
    chk("halt_hold_req", imem_req, 0);
    halt_req = 1'b0;
    @(negedge clk);
    chk("resume_halted", halted, 0);
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 32'h1C);
    // JAL to 0x40, then reset during the fetch wait
    run_inst(32'h0240_006F, 1'b0, 1'b1, 32'h24);
    chk("jal2_rfwe", rf_we, 0);
    chk("jal2_wbsel", wb_sel_pc4, 1);
    @(negedge clk);
    @(negedge clk);
    chk("wait40_req", imem_req, 1);
    chk("wait40_addr", imem_addr, 32'h40);
    rst = 1'b1;
    imem_rdata = 32'hDEAD_BEEF; imem_ack = 1'b1;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_ir", inst_encoding, 32'h13);
    chk("mid_rst_instret", instret, 0);
    @(negedge clk);
    chk("mid_rst_ack_ir", inst_encoding, 32'h13);
    imem_ack = 1'b0;
    rst = 1'b0;
    // Wrap: JAL -4 at 0 reaches 0xFFFFFFFC, next NOP wraps to 0
    run_inst(32'hFFDF_F06F, 1'b0, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_hi_pc", pc, 32'hFFFF_FFFC);
    run_inst(32'h13, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_instret", instret, 2);
    for (int i = 0; i < 4; i++) begin
      run_inst(32'h13, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
    end
    chk("pre_trap_pc", pc, 32'h10);
    // Misaligned JAL +6 at 0x10
    run_inst(32'h0060_00EF, 1'b1, 1'b1, 32'd6);
    chk("trap_wb_rfwe", rf_we, 0);
    chk("trap_wb_wbsel", wb_sel_pc4, 0);
    @(negedge clk);
    chk("trap_flag", trap, 1);
    chk("trap_pc", pc, 32'h10);
    chk("trap_instret", instret, 6);
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("trap_stay", {trap, imem_req, rf_we, alu_en, halted}, 5'b10000);
    end
    chk("trap_stay_pc", pc, 32'h10);
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("trap_clr", trap, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("trap_exit_req", imem_req, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
